uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  UART receive stage: the far-end consumer of the TX serializer's line output.
//  Oversamples RX_IN at PRESCALE x bit rate and majority-votes each bit.
//  Frame: start(0), DATA_WIDTH bits LSB-first, optional parity, stop(1).
//  Delivers a parallel word with a one-cycle valid pulse and per-frame error flags.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PRESCALE    8  Clk cycles per bit; even, >= 8
// PORTS
//  Clk           in   1           system clock, rising edge
//  Reset         in   1           asynchronous, active-high reset
//  RX_IN         in   1           serial line, idle high; asynchronous to Clk
//  Parity_EN     in   1           1 = frame carries a parity bit
//  Parity_TYPE   in   1           0 = even, 1 = odd
//  P_DATA        out  DATA_WIDTH  last good word; held until next good frame
//  Data_Valid    out  1           1-cycle pulse: P_DATA updated this cycle
//  Parity_Error  out  1           1-cycle pulse: parity mismatch
//  Stop_Error    out  1           1-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - Reset: state=IDLE, counters 0, synchronizer flops 1, P_DATA=0, all pulses 0.
//    Reset mid-frame aborts the frame silently; no pulse is produced.
//  - RX_IN passes a 2-flop synchronizer (reset to 1). All logic uses rx_s.
//  - edge_cnt 0..PRESCALE-1 wraps each bit period.
//  - bit_cnt counts data bits 0..DATA_WIDTH-1.
//  - Sampling: rx_s is captured at edge_cnt = P/2-1, P/2, P/2+1 (P=PRESCALE).
//    Bit value = majority of 3, registered at edge_cnt = P/2+2 (decision cycle).
//  - States: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   rx_s==0 -> START, edge_cnt=0.
//    START:  at decision, bit==1 -> IDLE (glitch, no flags); bit==0 -> continue.
//            At wrap -> DATA, bit_cnt=0.
//    DATA:   at decision, shift bit into shift reg, LSB first.
//            At wrap: bit_cnt==DATA_WIDTH-1 -> (Parity_EN ? PARITY : STOP),
//            else bit_cnt++.
//    PARITY: at decision, perr = bit ^ (^shift) ^ Parity_TYPE. At wrap -> STOP.
//    STOP:   at decision, evaluate frame and go to IDLE the next cycle.
//            Leaves the second half of stop bit for resync to the next start edge.
//  - Frame evaluation happens in one cycle. Outputs are registered, so pulses
//    appear the cycle after the decision:
//    Stop_Error   = (stop bit==0).
//    Parity_Error = Parity_EN & perr.
//    Data_Valid   = ~Stop_Error & ~Parity_Error; P_DATA <= shift only then.
//    Errors can pulse together.
//  - Parity_EN/Parity_TYPE are sampled on IDLE->START.
//    Changes mid-frame do not affect the current frame.
//  - Latency: Data_Valid pulses (1+DATA_WIDTH+Parity_EN)*P + P/2+4 Clk cycles
//    after the first RX_IN low, including the 2 synchronizer cycles.
//  - Back-to-back frames with zero idle bits are received without loss.
//  - RX_IN held low, i.e. a break: Stop_Error once.
//    Re-arms only after rx_s returns to 1, so no repeated false frames.
// STRUCTURE
//  - Shared package uart_pkg: state encodings UART_IDLE..UART_STOP, shared
//    with the TX FSM; START_BIT=0, STOP_BIT=1; PARITY_EVEN=0, PARITY_ODD=1.
//  - One sub-module, uart_rx_sampler: synchronizer, edge_cnt, 3-sample
//    majority vote. Outputs sampled_bit and a decision strobe.
//  - The top module holds the FSM, bit_cnt, shift register, parity and the
//    output registers.
// TESTING
//  1. 0xA5, no parity, P=8 -> one Data_Valid, P_DATA=0xA5, no errors.
//     Pulse lands 9*8+8 cycles after the start edge.
//  2. 0x3C with even parity bit 0, then odd with bit 1 -> Data_Valid both,
//     no Parity_Error. Same frames with the parity bit flipped ->
//     Parity_Error only, P_DATA unchanged.
//  3. Stop bit driven 0 on 0x55 -> Stop_Error pulse, no Data_Valid.
//     Line then held low 40 bit times -> no further pulses until RX_IN high.
//  4. 2-cycle low glitch on idle line -> returns to IDLE, no pulses.
//     Single-cycle glitch at a data-bit centre -> vote masks it, correct word.
//  5. Frames 0x01,0xFF,0x80 back-to-back, zero idle -> three Data_Valid in order.
//  6. Reset asserted mid-DATA, released, frame 0x96 sent -> no pulse for the
//     aborted frame, P_DATA=0x96.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive paths.
//   - uart_state_e : frame-phase encoding used by both TX and RX FSMs
//   - START_BIT / STOP_BIT : line levels of the framing bits
//   - PARITY_EVEN / PARITY_ODD : encoding of the Parity_TYPE input
//   - majority3() : 2-of-3 vote used to filter line noise
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Front end of the UART receiver: brings the asynchronous line into the
//   clock domain, tracks the position inside the current bit period and
//   majority-votes three samples taken around the bit centre.
//
//   Ports
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     rx_in        in   raw serial line (idle high)
//     start        in   start edge accepted this cycle; this cycle is bit
//                       position 0, so the counter continues at 1
//     busy         in   a frame is in progress (FSM not idle)
//     rx_s         out  synchronized line level
//     sampled_bit  out  majority of the three centre samples
//     decision     out  bit value is final this cycle
//     bit_end      out  last cycle of the current bit period
//
//   PRESCALE must be even and at least 8 so the three samples, the decision
//   cycle and the wrap are all distinct positions inside one bit period.
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic start,
    input  logic busy,
    output logic rx_s,
    output logic sampled_bit,
    output logic decision,
    output logic bit_end
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] CNT_S0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(PRESCALE / 2 + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic          sync1;
    logic [CW-1:0] edge_cnt;
    logic [2:0]    samples;

    // Two-flop synchronizer; resets to the idle line level so that reset
    // release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // Position inside the bit period. Held at 0 while idle; the start-edge
    // cycle counts as position 0 of the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (start) begin
            edge_cnt <= CW'(1);
        end else if (busy) begin
            edge_cnt <= (edge_cnt == CNT_LAST) ? '0 : edge_cnt + CW'(1);
        end else begin
            edge_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples <= '0;
        end else if (busy) begin
            if (edge_cnt == CNT_S0) samples[0] <= rx_s;
            if (edge_cnt == CNT_S1) samples[1] <= rx_s;
            if (edge_cnt == CNT_S2) samples[2] <= rx_s;
        end
    end

    assign sampled_bit = majority3(samples[0], samples[1], samples[2]);
    assign decision    = busy && (edge_cnt == CNT_DEC);
    assign bit_end     = busy && (edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//   UART receive stage. Frame: start(0), DATA_WIDTH bits LSB first,
//   optional parity bit, stop(1). Each bit is the majority of three
//   oversamples taken around its centre.
//
//   Ports
//     Clk           in   system clock, rising edge
//     Reset         in   asynchronous active-high reset
//     RX_IN         in   serial line, idle high, asynchronous to Clk
//     Parity_EN     in   1 = frame carries a parity bit (latched at start)
//     Parity_TYPE   in   0 = even, 1 = odd (latched at start)
//     P_DATA        out  last good word, held until the next good frame
//     Data_Valid    out  one-cycle pulse, P_DATA updated this cycle
//     Parity_Error  out  one-cycle pulse, parity mismatch
//     Stop_Error    out  one-cycle pulse, stop bit sampled low
//
//   Output protocol: there is no back-pressure. Data_Valid is a single-cycle
//   strobe meaning "P_DATA holds a newly received good word this cycle"; the
//   consumer must take it in that cycle. P_DATA keeps its value afterwards.
//   Parity_Error and Stop_Error are single-cycle strobes for the same frame
//   slot and may be high together; neither touches P_DATA.
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic                  Parity_EN,
    input  logic                  Parity_TYPE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    import uart_pkg::*;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    uart_state_e           state, state_next;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [DATA_WIDTH:0]   shift_in;
    logic                  pen_q, pen_next;
    logic                  ptype_q, ptype_next;
    logic                  perr_q, perr_next;
    logic                  rearm_wait, rearm_next;
    logic [DATA_WIDTH-1:0] p_data_next;
    logic                  dv_next, pe_next, se_next;
    logic                  start;

    logic rx_s;
    logic sampled_bit;
    logic decision;
    logic bit_end;

    uart_rx_sampler #(
        .PRESCALE(PRESCALE)
    ) u_sampler (
        .clk        (Clk),
        .rst        (Reset),
        .rx_in      (RX_IN),
        .start      (start),
        .busy       (state != UART_IDLE),
        .rx_s       (rx_s),
        .sampled_bit(sampled_bit),
        .decision   (decision),
        .bit_end    (bit_end)
    );

    // New bit enters at the MSB and the word shifts right, so after
    // DATA_WIDTH bits the first (LSB-first) bit sits at bit 0.
    assign shift_in = {sampled_bit, shift};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= UART_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            pen_q        <= 1'b0;
            ptype_q      <= PARITY_EVEN;
            perr_q       <= 1'b0;
            rearm_wait   <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shift        <= shift_next;
            pen_q        <= pen_next;
            ptype_q      <= ptype_next;
            perr_q       <= perr_next;
            rearm_wait   <= rearm_next;
            P_DATA       <= p_data_next;
            Data_Valid   <= dv_next;
            Parity_Error <= pe_next;
            Stop_Error   <= se_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        pen_next     = pen_q;
        ptype_next   = ptype_q;
        perr_next    = perr_q;
        rearm_next   = rearm_wait;
        p_data_next  = P_DATA;
        dv_next      = 1'b0;
        pe_next      = 1'b0;
        se_next      = 1'b0;
        start        = 1'b0;

        case (state)
            UART_IDLE: begin
                // After a framing error the line may be stuck low (break);
                // only a return to idle level allows a new start edge.
                if (rx_s == STOP_BIT) begin
                    rearm_next = 1'b0;
                end
                if (rx_s == START_BIT && !rearm_wait) begin
                    start      = 1'b1;
                    state_next = UART_START;
                    pen_next   = Parity_EN;
                    ptype_next = Parity_TYPE;
                    perr_next  = 1'b0;
                end
            end

            UART_START: begin
                // A start bit that votes high was a glitch: drop it quietly.
                if (decision && sampled_bit != START_BIT) begin
                    state_next = UART_IDLE;
                end else if (bit_end) begin
                    state_next   = UART_DATA;
                    bit_cnt_next = '0;
                end
            end

            UART_DATA: begin
                if (decision) begin
                    shift_next = shift_in[DATA_WIDTH:1];
                end
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_next = pen_q ? UART_PARITY : UART_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end

            UART_PARITY: begin
                if (decision) begin
                    perr_next = sampled_bit ^ (^shift) ^ ptype_q;
                end
                if (bit_end) begin
                    state_next = UART_STOP;
                end
            end

            UART_STOP: begin
                // Leave mid-stop-bit so the rest of the stop bit is spent in
                // IDLE, ready to catch a back-to-back start edge.
                if (decision) begin
                    se_next    = (sampled_bit != STOP_BIT);
                    pe_next    = pen_q & perr_q;
                    dv_next    = (sampled_bit == STOP_BIT) && !(pen_q & perr_q);
                    rearm_next = (sampled_bit != STOP_BIT);
                    if ((sampled_bit == STOP_BIT) && !(pen_q & perr_q)) begin
                        p_data_next = shift;
                    end
                    state_next = UART_IDLE;
                end
            end

            default: begin
                state_next = UART_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
//   Drives serial frames into uart_rx_deserializer. For every frame the
//   expected outcome (result cycle, flags, visible word) is computed from the
//   frame contents and pushed into exp_q; an independent monitor pops and
//   compares whenever the DUT raises any output pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int P  = 8;
    localparam int EW = 32 + 3 + DW;  // {due cycle, dv, pe, se, word}

    // ---------------- clock / reset ----------------
    logic          Clk = 1'b0;
    logic          Reset;
    logic          RX_IN;
    logic          Parity_EN;
    logic          Parity_TYPE;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Parity_Error;
    logic          Stop_Error;

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    uart_rx_deserializer #(
        .DATA_WIDTH(DW),
        .PRESCALE  (P)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RX_IN       (RX_IN),
        .Parity_EN   (Parity_EN),
        .Parity_TYPE (Parity_TYPE),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_word;   // word the receiver should currently hold
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Reference outcome of one frame, from its contents alone.
    task automatic expect_frame(input logic [DW-1:0] d, input logic pen, input logic ptype,
                                input logic pbit, input logic stop_val, input int unsigned t0);
        int          ones;
        logic        se, pe, dv;
        int unsigned due;
        ones = $countones(d) + ((pen && pbit) ? 1 : 0);
        se   = (stop_val == 1'b0);
        pe   = pen && ((ones % 2) != (ptype ? 1 : 0));
        dv   = !se && !pe;
        if (dv) model_word = d;
        due  = t0 + (1 + DW + (pen ? 1 : 0)) * P + P / 2 + 4;
        exp_q.push_back({due, dv, pe, se, model_word});
    endtask

    // ---------------- drivers ----------------
    task automatic drive_level(input logic v, input int n);
        for (int c = 0; c < n; c++) begin
            RX_IN = v;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input logic glitch);
        for (int c = 0; c < P; c++) begin
            RX_IN = (glitch && c == P / 2) ? ~v : v;
            @(posedge Clk);
            #1;
        end
    endtask

    // glitch_bit: data bit index that gets a one-cycle inversion at its
    // centre, or -1. scramble: wiggle the parity controls after the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptype,
                              input logic flip_par, input logic stop_val,
                              input int glitch_bit, input logic scramble);
        logic pbit;
        Parity_EN   = pen;
        Parity_TYPE = ptype;
        pbit = (^d) ^ ptype ^ flip_par;
        expect_frame(d, pen, ptype, pbit, stop_val, cyc + 1);
        drive_bit(1'b0, 1'b0);
        if (scramble) begin
            Parity_EN   = 1'($urandom_range(0, 1));
            Parity_TYPE = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < DW; i++) drive_bit(d[i], glitch_bit == i);
        if (pen) drive_bit(pbit, 1'b0);
        drive_bit(stop_val, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30 * P) begin
            @(posedge Clk);
            t++;
        end
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] got_v;
        if (!Reset && (Data_Valid || Parity_Error || Stop_Error)) begin
            n_vec++;
            got_v = {cyc, Data_Valid, Parity_Error, Stop_Error, P_DATA};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b word=%02h at cycle %0d, required no pulse",
                         Data_Valid, Parity_Error, Stop_Error, P_DATA, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL frame_result: got cyc=%0d dv=%0b pe=%0b se=%0b word=%02h, required cyc=%0d dv=%0b pe=%0b se=%0b word=%02h",
                             got_v[EW-1 -: 32], got_v[DW+2], got_v[DW+1], got_v[DW], got_v[DW-1:0],
                             exp_v[EW-1 -: 32], exp_v[DW+2], exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        logic [DW-1:0] d;
        logic pen, ptype, flip, stop_val;
        int glitch;

        Reset       = 1'b1;
        RX_IN       = 1'b1;
        Parity_EN   = 1'b0;
        Parity_TYPE = 1'b0;
        model_word  = '0;
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_p_data", 32'(P_DATA), 32'(model_word));
        check("reset_data_valid", 32'(Data_Valid), 32'd0);
        check("reset_parity_error", 32'(Parity_Error), 32'd0);
        check("reset_stop_error", 32'(Stop_Error), 32'd0);
        @(posedge Clk);
        #1;
        drive_level(1'b1, 2 * P);

        // Plain frame, latency is part of the expected record.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        wait_drain("a5");

        // Parity good/bad, even and odd.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        wait_drain("parity");

        // Bad stop bit followed by a long break: one error only.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        drive_level(1'b0, 40 * P);
        drive_level(1'b1, 2 * P);
        wait_drain("break");

        // Short start glitch, then a frame with a data-centre glitch.
        drive_level(1'b0, 2);
        drive_level(1'b1, 3 * P);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        drive_level(1'b1, P);
        wait_drain("glitch");

        // Back-to-back frames, no idle time.
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        drive_level(1'b1, 2 * P);
        wait_drain("b2b");

        // Reset in the middle of the data bits.
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        Reset      = 1'b1;
        RX_IN      = 1'b1;
        model_word = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("midframe_reset_p_data", 32'(P_DATA), 32'(model_word));
        @(posedge Clk);
        #1;
        drive_level(1'b1, 3 * P);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        drive_level(1'b1, P);
        wait_drain("after_reset");

        // Randomized frames with mixed settings, errors, glitches and gaps.
        for (int n = 0; n < 40; n++) begin
            d        = DW'($urandom);
            pen      = 1'($urandom_range(0, 1));
            ptype    = 1'($urandom_range(0, 1));
            flip     = ($urandom_range(0, 4) == 0);
            stop_val = ($urandom_range(0, 5) != 0);
            glitch   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            send_frame(d, pen, ptype, flip, stop_val, glitch, 1'b1);
            gap = stop_val ? int'($urandom_range(0, 2)) * P : P + int'($urandom_range(0, P));
            drive_level(1'b1, gap);
        end
        drive_level(1'b1, 2 * P);
        wait_drain("random");
        drive_level(1'b1, 4 * P);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
